// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch block.
package imem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2
  } fault_e;

  localparam logic [31:0] ILLEGAL_INSTR_DEFAULT = 32'hFCFFFFFF;
  localparam logic [31:0] NOP                   = 32'h00000000;

  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/imem_array.sv
// Single-port instruction RAM, DEPTH x DATA_W, registered read.
// Latency: read data valid one clock after re.
// Backpressure: none; a write in the same cycle takes priority over the read.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents deliberately have no reset so a loaded image survives rst_n.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch port: byte-addressed request, registered response with fault decode.
// Latency: response one clock after request accept; 1 fetch per clock sustained.
// Backpressure: req_ready drops while a response is held unconsumed or the loader writes.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int                ADDR_W        = 32,
  parameter int                DATA_W        = 32,
  parameter int                DEPTH         = 256,
  parameter logic [DATA_W-1:0] ILLEGAL_INSTR = ILLEGAL_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [1:0]        rsp_fault,
  input  logic              flush,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [15:0]       fault_cnt
);

  localparam int IW = clog2(DEPTH);

  fault_e            cause;
  fault_e            fault_q;
  logic              rd_q;
  logic              accept;
  logic              rsp_hs;
  logic              load_in_range;
  logic              ram_we;
  logic              ram_re;
  logic [IW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_load_lsb;

  assign req_ready = !load_en && (!rsp_valid || rsp_ready || flush);
  assign accept    = req_valid && req_ready;
  assign rsp_hs    = rsp_valid && rsp_ready;

  // Misalignment is checked first so it wins over out-of-range.
  always_comb begin
    cause = FAULT_NONE;
    if (req_addr[1:0] != 2'b00) begin
      cause = FAULT_MISALIGN;
    end else if (req_addr[ADDR_W-1:IW+2] != '0) begin
      cause = FAULT_RANGE;
    end
  end

  assign load_in_range   = (load_addr[ADDR_W-1:IW+2] == '0);
  assign unused_load_lsb = ^load_addr[1:0];

  // Loader and fetch never collide: load_en already blocks accept.
  assign ram_we   = load_en && load_in_range;
  assign ram_re   = accept && (cause == FAULT_NONE);
  assign ram_addr = load_en ? load_addr[IW+1:2] : req_addr[IW+1:2];

  imem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IW     (IW)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (load_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_addr  <= '0;
      fault_q   <= FAULT_NONE;
      rd_q      <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_addr  <= req_addr;
      fault_q   <= cause;
      rd_q      <= (cause == FAULT_NONE);
    end else if (rsp_ready || flush) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_cnt <= 16'd0;
    end else if (rsp_hs && (fault_q != FAULT_NONE) && (fault_cnt != 16'hFFFF)) begin
      fault_cnt <= fault_cnt + 16'd1;
    end
  end

  // rd_q is clear after reset, so rsp_instr reads as NOP until the first good fetch.
  always_comb begin
    rsp_instr = NOP;
    if (rd_q) begin
      rsp_instr = ram_rdata;
    end else if (fault_q != FAULT_NONE) begin
      rsp_instr = ILLEGAL_INSTR;
    end
  end

  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_imem_fetch.sv
// Bench for imem_fetch: vector table plus scoreboarded corner-case sequences.
module tb_imem_fetch;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } exp_t;

  localparam logic [31:0] ILL = 32'hFCFFFFFF;
  localparam int          NV  = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic [15:0] fault_cnt;

  imem_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .fault_cnt (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          hs_cnt = 0;
  int          last_hs_cyc = 0;
  int          prev_hs_cyc = 0;
  exp_t        sb [$];
  exp_t        mon_e;
  exp_t        vecs [NV];
  logic [31:0] model [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response monitor: samples just before each rising edge.
  always @(negedge clk) begin
    #4;
    if (!rst_n) begin
      sb.delete();
    end else if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp actual addr=%h expected no response", rsp_addr);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_instr", rsp_instr, mon_e.instr);
        chk("rsp_addr", rsp_addr, mon_e.addr);
        chk("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
      end
      prev_hs_cyc = last_hs_cyc;
      last_hs_cyc = cyc;
      hs_cnt++;
    end else if (rsp_valid && flush) begin
      if (sb.size() != 0) void'(sb.pop_front());
    end
  end

  function automatic exp_t model_exp(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    if (a[1:0] != 2'b00) begin
      e.fault = 2'd1;
      e.instr = ILL;
    end else if (a[31:10] != 22'd0) begin
      e.fault = 2'd2;
      e.instr = ILL;
    end else begin
      e.fault = 2'd0;
      e.instr = model[a[9:2]];
    end
    return e;
  endfunction

  // Called at a falling edge; returns at the falling edge after the accept, req_valid still high.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef);
    bit   got = 1'b0;
    exp_t e;
    req_valid = 1'b1;
    req_addr  = a;
    for (int i = 0; i < 20 && !got; i++) begin
      #4;
      if (req_ready) begin
        e.addr  = a;
        e.instr = ei;
        e.fault = ef;
        sb.push_back(e);
        got = 1'b1;
      end
      @(negedge clk);
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL fetch_timeout addr=%h actual req_ready=%b expected 1", a, req_ready);
    end
  endtask

  task automatic fetch_m(input logic [31:0] a);
    exp_t e;
    e = model_exp(a);
    fetch(a, e.instr, e.fault);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    if (a[31:10] == 22'd0) model[a[9:2]] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int h0;
    int exp_fc;

    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;

    vecs[0] = '{32'h0000_0006, ILL,          2'd1};
    vecs[1] = '{32'h0000_0400, ILL,          2'd2};
    vecs[2] = '{32'h0000_0000, 32'h21080002, 2'd0};
    vecs[3] = '{32'h0000_03FC, 32'hDEADBEEF, 2'd0};
    vecs[4] = '{32'h0000_0402, ILL,          2'd1};
    vecs[5] = '{32'h8000_0000, ILL,          2'd2};
    vecs[6] = '{32'h0000_0008, 32'h12345678, 2'd0};
    vecs[7] = '{32'h0000_0004, 32'h214A0002, 2'd0};

    #2;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_addr", rsp_addr, 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    chk("rst_fault_cnt", 32'(fault_cnt), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    load(32'h0, 32'h21080002);
    load(32'h4, 32'h214A0002);
    load(32'h8, 32'h12345678);
    load(32'h3FC, 32'hDEADBEEF);
    load(32'hC, 32'hAAAA0001);
    load(32'h400, 32'h55555555);

    // Back-to-back fetches must handshake on consecutive cycles.
    rsp_ready = 1'b1;
    h0 = hs_cnt;
    fetch(32'h0, 32'h21080002, 2'd0);
    fetch(32'h4, 32'h214A0002, 2'd0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("b2b_count", 32'(hs_cnt - h0), 32'd2);
    chk("b2b_gap", 32'(last_hs_cyc - prev_hs_cyc), 32'd1);

    exp_fc = 0;
    for (int i = 0; i < NV; i++) begin
      fetch(vecs[i].addr, vecs[i].instr, vecs[i].fault);
      req_valid = 1'b0;
      @(negedge clk);
      if (vecs[i].fault != 2'd0) exp_fc++;
      chk("vec_fault_cnt", 32'(fault_cnt), 32'(exp_fc));
    end

    // Hold under backpressure with a competing request pending.
    rsp_ready = 1'b0;
    fetch(32'h8, 32'h12345678, 2'd0);
    req_addr = 32'h4;
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_instr", rsp_instr, 32'h12345678);
      chk("hold_addr", rsp_addr, 32'h8);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    h0 = hs_cnt;
    repeat (2) @(negedge clk);
    chk("hold_once", 32'(hs_cnt - h0), 32'd1);
    chk("hold_drained", 32'(rsp_valid), 32'd0);

    // Flush with a simultaneous accept replaces the held response.
    rsp_ready = 1'b0;
    fetch(32'h0, 32'h21080002, 2'd0);
    req_valid = 1'b0;
    flush = 1'b1;
    h0 = hs_cnt;
    fetch(32'h4, 32'h214A0002, 2'd0);
    flush = 1'b0;
    req_valid = 1'b0;
    chk("flush_valid", 32'(rsp_valid), 32'd1);
    chk("flush_addr", rsp_addr, 32'h4);
    chk("flush_instr", rsp_instr, 32'h214A0002);
    chk("flush_no_hs", 32'(hs_cnt - h0), 32'd0);
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);

    // A flushed faulted response is not counted.
    rsp_ready = 1'b0;
    fetch(32'h6, ILL, 2'd1);
    req_valid = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_only_valid", 32'(rsp_valid), 32'd0);
    chk("flush_fault_cnt", 32'(fault_cnt), 32'(exp_fc));

    // Load the word right after its fetch was accepted: old data returns.
    rsp_ready = 1'b1;
    fetch(32'hC, 32'hAAAA0001, 2'd0);
    req_valid = 1'b0;
    load(32'hC, 32'hBBBB0002);
    fetch_m(32'hC);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Loader stalls the request port.
    req_valid = 1'b1;
    req_addr  = 32'h0;
    load_en   = 1'b1;
    load_addr = 32'h10;
    load_data = 32'h0BADF00D;
    model[4]  = 32'h0BADF00D;
    #4;
    chk("load_stall_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    load_en   = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);

    // Reset with a faulted response held.
    rsp_ready = 1'b0;
    fetch(32'h6, ILL, 2'd1);
    req_valid = 1'b0;
    chk("prerst_valid", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_fault_cnt", 32'(fault_cnt), 32'd0);
    chk("midrst_fault", 32'(rsp_fault), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    fetch_m(32'h0);
    fetch_m(32'h10);
    fetch_m(32'h3FC);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("post_rst_fault_cnt", 32'(fault_cnt), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
